// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Function : 16-bit SPI mode-0 frame transmitter {rw, addr[6:0], data[7:0]}, MSB first.
//            Define SPI_CTRL_PENDING_EN to add a one-entry pending frame buffer.
// Revision : 1.0
// ============================================================================
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [7:0] C_CNT_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_bit;
  logic [15:0] r_shift;

  logic        w_cnt_last;
  logic        w_accept;
  logic [15:0] w_req_word;
  logic        w_chain;
  logic [15:0] w_chain_word;

  assign w_cnt_last = (r_cnt == C_CNT_LAST);
  assign w_accept   = req_valid & req_ready;
  assign w_req_word = {req_rw, req_addr, req_data};

`ifdef SPI_CTRL_PENDING_EN
  logic        r_pend_valid;
  logic [15:0] r_pend_word;
  logic        w_gap_end;

  assign w_gap_end = (r_state == S_GAP) && w_cnt_last;
  // A full buffer also covers the cycle it drains into the shifter.
  assign req_ready = ~r_pend_valid;
  assign w_chain      = r_pend_valid | w_accept;
  assign w_chain_word = r_pend_valid ? r_pend_word : w_req_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_word  <= 16'h0000;
    end else if (w_accept && (r_state != S_IDLE) && !w_gap_end) begin
      r_pend_valid <= 1'b1;
      r_pend_word  <= w_req_word;
    end else if (w_gap_end) begin
      r_pend_valid <= 1'b0;
    end
  end
`else
  assign req_ready    = (r_state == S_IDLE);
  assign w_chain      = 1'b0;
  assign w_chain_word = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_bit   <= 4'd0;
      r_shift <= 16'h0000;
    end else begin
      if (r_state == S_IDLE || w_cnt_last) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETUP;
            r_shift <= w_req_word;
            r_bit   <= 4'd0;
          end
        end
        S_SETUP: begin
          if (w_cnt_last) r_state <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          if (w_cnt_last) begin
            // Bit 0 has been clocked out once r_bit reaches 15; never wrap.
            if (r_bit == 4'd15) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_SHIFT_LO;
              r_shift <= {r_shift[14:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
            end
          end
        end
        S_SHIFT_LO: begin
          if (w_cnt_last) r_state <= S_SHIFT_HI;
        end
        S_HOLD: begin
          if (w_cnt_last) r_state <= S_GAP;
        end
        S_GAP: begin
          if (w_cnt_last) begin
            if (w_chain) begin
              r_state <= S_SETUP;
              r_shift <= w_chain_word;
              r_bit   <= 4'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sclk = (r_state == S_SHIFT_HI);
  assign ncs  = ~((r_state == S_SETUP) || (r_state == S_SHIFT_HI) ||
                  (r_state == S_SHIFT_LO) || (r_state == S_HOLD));
  assign copi = r_shift[15] & ~ncs;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_GAP) && (r_cnt == 8'd0);

endmodule
`default_nettype wire
